// File: rtl/arm_pipe_pkg.sv
`default_nettype none
// arm_pipe_pkg: shared types and constants for the ARM pipeline hazard scoreboard.
package arm_pipe_pkg;
  localparam int REG_IDX_W = 4;
  localparam int FWD_RF    = 0;

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] dest;
    logic                 is_load;
  } slot_t;
endpackage
`default_nettype wire

// File: rtl/hazard_sb_slot.sv
`default_nettype none
// hazard_sb_slot: one in-flight destination slot with hold/load/clear and
// the two source-operand comparators against the instruction in ID.
module hazard_sb_slot
  import arm_pipe_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hold,
  input  slot_t                d,
  output slot_t                q,
  input  logic [REG_IDX_W-1:0] src1,
  input  logic [REG_IDX_W-1:0] src2,
  input  logic                 two_src,
  output logic                 hit_a,
  output logic                 hit_b
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (!hold) begin
      q <= d;
    end
  end

  assign hit_a = q.valid && (q.dest == src1);
  assign hit_b = q.valid && two_src && (q.dest == src2);
endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// hazard_scoreboard: DEPTH-slot destination tracker producing the ID freeze and
// operand forwarding selects. Forwarding is compiled in with HAZARD_FORWARD_EN.
module hazard_scoreboard
  import arm_pipe_pkg::*;
#(
  parameter int REG_ADDR_W = REG_IDX_W,
  parameter int DEPTH      = 2,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall_in,
  input  logic                         flush,
  input  logic                         wb_en_id,
  input  logic                         mem_read_id,
  input  logic [REG_ADDR_W-1:0]        dest_id,
  input  logic [REG_ADDR_W-1:0]        src1_id,
  input  logic [REG_ADDR_W-1:0]        src2_id,
  input  logic                         two_src_id,
  output logic                         hazard,
  output logic [$clog2(DEPTH+1)-1:0]   fwd_sel_a,
  output logic [$clog2(DEPTH+1)-1:0]   fwd_sel_b,
  output logic [CNT_W-1:0]             stall_count
);
  localparam int FWD_W = $clog2(DEPTH+1);

  slot_t                id_slot;
  slot_t                slot_d [DEPTH];
  slot_t                slot_q [DEPTH];
  logic [DEPTH-1:0]     hit_a;
  logic [DEPTH-1:0]     hit_b;
  logic [REG_IDX_W-1:0] src1_w;
  logic [REG_IDX_W-1:0] src2_w;
  logic                 unused_tail;

  assign src1_w = REG_IDX_W'(src1_id);
  assign src2_w = REG_IDX_W'(src2_id);

  // A frozen or flushed ID instruction becomes a bubble in EXE.
  always_comb begin
    id_slot = '0;
    if (!hazard && !flush) begin
      id_slot.valid   = wb_en_id;
      id_slot.dest    = REG_IDX_W'(dest_id);
      id_slot.is_load = mem_read_id & wb_en_id;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    if (k == 0) begin : g_head
      assign slot_d[k] = id_slot;
    end else begin : g_tail
      assign slot_d[k] = slot_q[k-1];
    end

    hazard_sb_slot u_slot (
      .clk     (clk),
      .rst     (rst),
      .hold    (stall_in),
      .d       (slot_d[k]),
      .q       (slot_q[k]),
      .src1    (src1_w),
      .src2    (src2_w),
      .two_src (two_src_id),
      .hit_a   (hit_a[k]),
      .hit_b   (hit_b[k])
    );
  end

  // The oldest slot retires into WB; nothing downstream reads it here.
  assign unused_tail = ^slot_q[DEPTH-1];

`ifdef HAZARD_FORWARD_EN
  logic [FWD_W-1:0] idx_a;
  logic [FWD_W-1:0] idx_b;
  logic             any_a;
  logic             any_b;

  // Scan oldest to youngest so the lowest matching index is left standing.
  always_comb begin
    idx_a = '0;
    idx_b = '0;
    any_a = 1'b0;
    any_b = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (hit_a[k]) begin
        any_a = 1'b1;
        idx_a = FWD_W'(k);
      end
      if (hit_b[k]) begin
        any_b = 1'b1;
        idx_b = FWD_W'(k);
      end
    end
  end

  assign hazard    = slot_q[0].is_load & (hit_a[0] | hit_b[0]);
  assign fwd_sel_a = any_a ? idx_a + FWD_W'(1) : FWD_W'(FWD_RF);
  assign fwd_sel_b = any_b ? idx_b + FWD_W'(1) : FWD_W'(FWD_RF);
`else
  assign hazard    = |{hit_a, hit_b};
  assign fwd_sel_a = FWD_W'(FWD_RF);
  assign fwd_sel_b = FWD_W'(FWD_RF);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (!stall_in && hazard && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// tb_hazard_scoreboard: directed scoreboard bench for hazard_scoreboard
// (DEPTH=2, CNT_W=4); expectations follow the HAZARD_FORWARD_EN build setting.
module tb_hazard_scoreboard;
  localparam int DEPTH = 2;
  localparam int CNT_W = 4;
  localparam int FW    = $clog2(DEPTH + 1);
`ifdef HAZARD_FORWARD_EN
  localparam int LU_BUBBLES  = 1;
  localparam int ALU_BUBBLES = 0;
`else
  localparam int LU_BUBBLES  = 2;
  localparam int ALU_BUBBLES = 2;
`endif

  logic clk = 1'b0, rst = 1'b0, stall_in = 1'b0, flush = 1'b0;
  logic wb_en_id = 1'b0, mem_read_id = 1'b0, two_src_id = 1'b0;
  logic [3:0] dest_id = '0, src1_id = '0, src2_id = '0;
  logic hazard;
  logic [FW-1:0] fwd_sel_a, fwd_sel_b;
  logic [CNT_W-1:0] stall_count;

  hazard_scoreboard #(.REG_ADDR_W(4), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stall_in(stall_in), .flush(flush),
    .wb_en_id(wb_en_id), .mem_read_id(mem_read_id), .dest_id(dest_id),
    .src1_id(src1_id), .src2_id(src2_id), .two_src_id(two_src_id),
    .hazard(hazard), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct { bit v; int d; bit ld; } mslot_t;
  typedef struct { logic hz; logic [FW-1:0] fa; logic [FW-1:0] fb; logic [CNT_W-1:0] cnt; } exp_t;

  mslot_t m [DEPTH];
  int     mcnt;
  exp_t   sb [$];
  int     checks = 0;
  int     fails  = 0;
  bit     last_hz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model_eval();
    exp_t e;
    int ia = -1;
    int ib = -1;
    for (int k = 0; k < DEPTH; k++) begin
      if (ia < 0 && m[k].v && m[k].d == int'(src1_id)) ia = k;
      if (ib < 0 && two_src_id && m[k].v && m[k].d == int'(src2_id)) ib = k;
    end
`ifdef HAZARD_FORWARD_EN
    e.hz = m[0].ld && (ia == 0 || ib == 0);
    e.fa = (ia < 0) ? '0 : FW'(ia + 1);
    e.fb = (ib < 0) ? '0 : FW'(ib + 1);
`else
    e.hz = (ia >= 0) || (ib >= 0);
    e.fa = '0;
    e.fb = '0;
`endif
    e.cnt = CNT_W'(mcnt);
    return e;
  endfunction

  task automatic step(input bit st, input bit fl, input bit wb, input bit ld,
                      input int d, input int s1, input int s2, input bit two);
    exp_t e;
    stall_in = st; flush = fl; wb_en_id = wb; mem_read_id = ld;
    dest_id = 4'(d); src1_id = 4'(s1); src2_id = 4'(s2); two_src_id = two;
    #1;
    sb.push_back(model_eval());
    e = sb.pop_front();
    chk("hazard", 32'(hazard), 32'(e.hz));
    if (!e.hz) begin
      chk("fwd_sel_a", 32'(fwd_sel_a), 32'(e.fa));
      chk("fwd_sel_b", 32'(fwd_sel_b), 32'(e.fb));
    end
    chk("stall_count", 32'(stall_count), 32'(e.cnt));
    last_hz = e.hz;
    @(posedge clk);
    if (!st) begin
      if (e.hz && mcnt < (2**CNT_W - 1)) mcnt++;
      for (int k = DEPTH - 1; k > 0; k--) m[k] = m[k-1];
      m[0].v  = !e.hz && !fl && wb;
      m[0].d  = d;
      m[0].ld = ld && wb;
    end
    @(negedge clk);
  endtask

  // Hold the ID instruction until it is accepted, with a cycle budget.
  task automatic issue(input bit wb, input bit ld, input int d, input int s1,
                       input int s2, input bit two);
    int n = 0;
    do begin
      step(1'b0, 1'b0, wb, ld, d, s1, s2, two);
      n++;
    end while (last_hz && n < 8);
    chk("issue_bound", 32'(last_hz), 32'd0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_hazard", 32'(hazard), 32'd0);
    chk("rst_fwd_a", 32'(fwd_sel_a), 32'd0);
    chk("rst_fwd_b", 32'(fwd_sel_b), 32'd0);
    chk("rst_count", 32'(stall_count), 32'd0);
    foreach (m[k]) m[k] = '{1'b0, 0, 1'b0};
    mcnt = 0;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    do_reset();
    idle();

    // ALU to ALU: immediate consumer, then next-but-one consumer
    issue(1, 0, 1, 2, 3, 1);
    issue(1, 0, 2, 1, 3, 1);
    do_reset();
    issue(1, 0, 1, 2, 3, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 0, 9, 9, 1'b0);
    issue(1, 0, 2, 1, 0, 0);

    // Load-use with both operands reading the load result
    do_reset();
    issue(1, 1, 4, 0, 0, 0);
    issue(1, 0, 5, 4, 4, 1);
    idle();
    chk("loaduse_count", 32'(stall_count), LU_BUBBLES);

    // Back-to-back ALU dependency
    do_reset();
    issue(1, 0, 1, 2, 3, 0);
    issue(1, 0, 2, 1, 0, 0);
    idle();
    chk("alu_dep_count", 32'(stall_count), ALU_BUBBLES);

    // External stall holds the scoreboard; flush during stall is ignored
    do_reset();
    issue(1, 1, 7, 0, 0, 0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 8, 7, 0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 8, 7, 0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 8, 7, 0, 1'b0);
    chk("stall_hold_count", 32'(stall_count), 32'd0);
    issue(1, 0, 8, 7, 0, 0);
    idle();
    chk("after_stall_count", 32'(stall_count), LU_BUBBLES);

    // Flush together with hazard: bubble enters, counter still steps
    do_reset();
    issue(1, 1, 4, 0, 0, 0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 5, 4, 0, 1'b0);
    idle();
    chk("flush_count", 32'(stall_count), 32'd1);

    // Youngest producer wins when two slots hold the same destination
    do_reset();
    issue(1, 0, 1, 2, 3, 1);
    issue(1, 0, 1, 5, 6, 1);
    issue(1, 0, 2, 1, 1, 1);

    // Counter saturation over 20+ hazard cycles
    do_reset();
    repeat (20) begin
      issue(1, 1, 4, 0, 0, 0);
      issue(1, 0, 5, 4, 0, 0);
    end
    idle();
    chk("sat_count", 32'(stall_count), 32'd15);

    // Asynchronous reset mid-cycle with a live load-use hazard
    do_reset();
    issue(1, 1, 4, 0, 0, 0);
    wb_en_id = 1'b1; mem_read_id = 1'b0; dest_id = 4'd5;
    src1_id = 4'd4; src2_id = 4'd0; two_src_id = 1'b0;
    #1;
    chk("pre_rst_hazard", 32'(hazard), 32'd1);
    do_reset();
    idle();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
`default_nettype wire
